rs_load_store: RTL and testbench
================================

RS_LOAD_STORE -- requirements
Module: rs_load_store

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of reservation-station entries (range 2..8).
REQ-002 SHALL have parameter TAG_BASE, default 4'd5, meaning the tag of entry 0; entry i owns tag TAG_BASE+i; tag 0 means the value is present.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 CLR  in  1  reset, synchronous, active-high.
REQ-005 issue_valid  in  1  issue request; issue_op in 6 ([5:3] Rd, [2:0] opcode); issue_offset in 16.
REQ-006 issue_vj/issue_qj  in  16/4  base value and tag; issue_vk/issue_qk  in  16/4  store data and tag.
REQ-007 issue_ready  out  1  at least one free entry.
REQ-008 cdb_valid/cdb_tag/cdb_data  in  1/4/16  common-data-bus broadcast.
REQ-009 start  out  1; ID_RS  out  4; Dado1/Dado2/Dado3  out  16 each (offset/base/store data); OP_Rd  out  6: address-unit request.
REQ-010 busy/confirmacao  in  1/1  address-unit status; finalizado  out  1  release pulse to the unit.
REQ-011 occupancy  out  4  count of valid entries.

Function
REQ-012 Entry fields: valid, op, offset, Vj, Qj, Vk, Qk, inflight.
REQ-013 Issue when issue_valid && issue_ready writes the lowest-index free entry; issue_valid while not issue_ready is dropped.
REQ-014 CDB with cdb_valid and cdb_tag!=0 SHALL replace every matching Qj/Qk with 0 and the corresponding V with cdb_data; issue-cycle operands matching the broadcast SHALL be captured from cdb_data (same-cycle bypass).
REQ-015 Entry ready: valid, not inflight, Qj==0, and (Qk==0 or opcode!=OP_SW).
REQ-016 FSM states IDLE, WAIT_CONF, FIN.
REQ-017 IDLE: if any entry ready, busy==0 and confirmacao==0, select lowest-index ready entry, drive start=1 for exactly one cycle with ID_RS=TAG_BASE+idx, Dado1=offset, Dado2=Vj, Dado3=Vk, OP_Rd=op; set inflight; go WAIT_CONF.
REQ-018 Request outputs are registered: start appears the cycle after the entry becomes ready; Dado*/ID_RS/OP_Rd hold stable until FIN ends.
REQ-019 WAIT_CONF: on confirmacao==1 go FIN; otherwise remain (no timeout).
REQ-020 FIN: finalizado=1 for exactly one cycle; the inflight entry is freed at the end of FIN; return to IDLE.
REQ-021 issue_ready/occupancy derive from registered state; an entry freed in FIN is reusable from the following cycle.
REQ-022 Simultaneous issue, CDB, and free in one cycle SHALL all take effect; the entry freed and the entry issued are never the same.

Reset
REQ-023 CLR SHALL clear all entries, state=IDLE, start=0, finalizado=0, ID_RS=0, Dado1..3=0, OP_Rd=0, occupancy=0, issue_ready=1.
REQ-024 CLR in any state, including WAIT_CONF, SHALL abandon the in-flight request without emitting finalizado.

Configuration
REQ-025 Macro RS_LS_FLUSH_EN: when defined, input flush (1 bit) SHALL invalidate every non-inflight entry next edge while the in-flight handshake completes normally; when undefined, the port and logic are absent.

Structure
REQ-026 Package rs_ls_pkg SHALL hold DEPTH/TAG_BASE defaults, OP_LW=3'b100, OP_SW=3'b101, the entry struct, and the FSM state enum.
REQ-027 Sub-module rs_ls_pick SHALL provide combinational lowest-index priority select (used for free-slot and ready-entry pick).

Verification
REQ-028 Issue LW offset=4, vj=0x0010, qj=0 -> start 1 cycle later, ID_RS=5, Dado1=4, Dado2=0x0010; model confirmacao next cycle -> finalizado one cycle; occupancy back to 0.
REQ-029 Issue SW qk=7, then CDB tag 7 data 0xBEEF -> no start before broadcast; start with Dado3=0xBEEF the cycle after.
REQ-030 Issue with issue_qj=6 in the same cycle as CDB tag 6 data 0x1234 -> entry stored ready, Dado2=0x1234.
REQ-031 Fill 4 entries -> issue_ready=0, 5th issue dropped; after first FIN, issue_ready=1 the next cycle.
REQ-032 Hold busy=1 with ready entries -> start stays 0; release busy -> lowest-index entry dispatched.
REQ-033 CLR during WAIT_CONF -> all outputs reset values next cycle, finalizado never asserted.

Source files
------------

// File: rtl/rs_ls_pkg.sv
// Shared types and constants for the load/store reservation station.
package rs_ls_pkg;

  localparam int unsigned RS_DEPTH_DEF = 4;
  localparam logic [3:0]  RS_TAG_BASE_DEF = 4'd5;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OPC_W-1:0] OP_LW = 3'b100;
  localparam logic [OPC_W-1:0] OP_SW = 3'b101;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
    logic              inflight;
  } rs_entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CONF = 2'd1,
    FIN       = 2'd2
  } rs_state_t;

  // A broadcast resolves an operand only when it carries a real (non-zero) tag.
  function automatic logic cdb_hit(input logic             vld,
                                   input logic [TAG_W-1:0] tag,
                                   input logic [TAG_W-1:0] q);
    return vld && (tag != '0) && (q == tag);
  endfunction

endpackage

// File: rtl/rs_ls_pick.sv
// Lowest-index priority select over a request vector.
module rs_ls_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rs_load_store.sv
// Load/store reservation station feeding a single address unit.
// Optional RS_LS_FLUSH_EN adds a flush input that drops all non-inflight entries.
module rs_load_store
  import rs_ls_pkg::*;
#(
  parameter int unsigned      DEPTH    = RS_DEPTH_DEF,
  parameter logic [TAG_W-1:0] TAG_BASE = RS_TAG_BASE_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_offset,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic              issue_ready,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              start,
  output logic [TAG_W-1:0]  ID_RS,
  output logic [DATA_W-1:0] Dado1,
  output logic [DATA_W-1:0] Dado2,
  output logic [DATA_W-1:0] Dado3,
  output logic [OP_W-1:0]   OP_Rd,
  input  logic              busy,
  input  logic              confirmacao,
  output logic              finalizado,
`ifdef RS_LS_FLUSH_EN
  input  logic              flush,
`endif
  output logic [CNT_W-1:0]  occupancy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t         ent_q [DEPTH];
  rs_entry_t         ent_d [DEPTH];
  rs_entry_t         issue_ent;
  rs_state_t         state_q, state_d;

  logic [DEPTH-1:0]  free_vec, ready_vec;
  logic              free_found, ready_found;
  logic [IDX_W-1:0]  free_idx, ready_idx, fly_idx_q;
  logic              dispatch, issue_fire, flush_c;

  logic              start_d, fin_d, issue_ready_d;
  logic [TAG_W-1:0]  id_d;
  logic [DATA_W-1:0] d1_d, d2_d, d3_d;
  logic [OP_W-1:0]   op_d;
  logic [CNT_W-1:0]  occ_d;

`ifdef RS_LS_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Per-entry free and dispatch-ready flags.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      free_vec[i]  = !ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid && !ent_q[i].inflight && (ent_q[i].qj == '0) &&
                     ((ent_q[i].qk == '0) || (ent_q[i].op[OPC_W-1:0] != OP_SW));
    end
  end

  rs_ls_pick #(.N(DEPTH), .IW(IDX_W)) u_pick_free (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_ls_pick #(.N(DEPTH), .IW(IDX_W)) u_pick_ready (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  assign issue_fire = issue_valid && free_found;
  assign dispatch   = (state_q == IDLE) && ready_found && !busy && !confirmacao && !flush_c;

  // Incoming entry, with same-cycle CDB bypass on both operands.
  always_comb begin
    issue_ent          = '0;
    issue_ent.valid    = 1'b1;
    issue_ent.op       = issue_op;
    issue_ent.offset   = issue_offset;
    issue_ent.vj       = issue_vj;
    issue_ent.qj       = issue_qj;
    issue_ent.vk       = issue_vk;
    issue_ent.qk       = issue_qk;
    if (cdb_hit(cdb_valid, cdb_tag, issue_qj)) begin
      issue_ent.qj = '0;
      issue_ent.vj = cdb_data;
    end
    if (cdb_hit(cdb_valid, cdb_tag, issue_qk)) begin
      issue_ent.qk = '0;
      issue_ent.vk = cdb_data;
    end
  end

  // Entry update: CDB capture, flush, release, dispatch mark, then issue write.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = ent_q[i];
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_q[i].valid && cdb_hit(cdb_valid, cdb_tag, ent_q[i].qj)) begin
        ent_d[i].qj = '0;
        ent_d[i].vj = cdb_data;
      end
      if (ent_q[i].valid && cdb_hit(cdb_valid, cdb_tag, ent_q[i].qk)) begin
        ent_d[i].qk = '0;
        ent_d[i].vk = cdb_data;
      end
      if (flush_c && !ent_q[i].inflight) ent_d[i] = '0;
    end
    if (state_q == FIN) ent_d[fly_idx_q] = '0;
    if (dispatch) ent_d[ready_idx].inflight = 1'b1;
    if (issue_fire) ent_d[free_idx] = issue_ent;
  end

  // Status is registered from the next entry state so it tracks the entry array exactly.
  always_comb begin
    occ_d         = '0;
    issue_ready_d = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + CNT_W'(ent_d[i].valid);
      if (!ent_d[i].valid) issue_ready_d = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (CLR) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (dispatch) state_d = WAIT_CONF;
      WAIT_CONF: if (confirmacao) state_d = FIN;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead and registered below.
  always_comb begin
    start_d = 1'b0;
    fin_d   = 1'b0;
    id_d    = ID_RS;
    d1_d    = Dado1;
    d2_d    = Dado2;
    d3_d    = Dado3;
    op_d    = OP_Rd;
    case (state_q)
      IDLE: begin
        if (dispatch) begin
          start_d = 1'b1;
          id_d    = TAG_BASE + TAG_W'(ready_idx);
          d1_d    = ent_q[ready_idx].offset;
          d2_d    = ent_q[ready_idx].vj;
          d3_d    = ent_q[ready_idx].vk;
          op_d    = ent_q[ready_idx].op;
        end
      end
      WAIT_CONF: if (confirmacao) fin_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      start       <= 1'b0;
      finalizado  <= 1'b0;
      ID_RS       <= '0;
      Dado1       <= '0;
      Dado2       <= '0;
      Dado3       <= '0;
      OP_Rd       <= '0;
      fly_idx_q   <= '0;
      occupancy   <= '0;
      issue_ready <= 1'b1;
    end else begin
      start       <= start_d;
      finalizado  <= fin_d;
      ID_RS       <= id_d;
      Dado1       <= d1_d;
      Dado2       <= d2_d;
      Dado3       <= d3_d;
      OP_Rd       <= op_d;
      occupancy   <= occ_d;
      issue_ready <= issue_ready_d;
      if (dispatch) fly_idx_q <= ready_idx;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CLR) ent_q[i] <= '0;
      else     ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_rs_load_store.sv
// Directed self-checking bench for rs_load_store (default build, DEPTH=4, TAG_BASE=5).
module tb_rs_load_store;

  logic        CLK, CLR;
  logic        issue_valid;
  logic [5:0]  issue_op;
  logic [15:0] issue_offset, issue_vj, issue_vk;
  logic [3:0]  issue_qj, issue_qk;
  logic        issue_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        start;
  logic [3:0]  ID_RS;
  logic [15:0] Dado1, Dado2, Dado3;
  logic [5:0]  OP_Rd;
  logic        busy, confirmacao, finalizado;
  logic [3:0]  occupancy;
`ifdef RS_LS_FLUSH_EN
  logic        flush;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] LW_R2 = 6'b010_100;
  localparam logic [5:0] SW_R0 = 6'b000_101;
  localparam logic [5:0] LW_R3 = 6'b011_100;

  rs_load_store dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .issue_valid  (issue_valid),
    .issue_op     (issue_op),
    .issue_offset (issue_offset),
    .issue_vj     (issue_vj),
    .issue_qj     (issue_qj),
    .issue_vk     (issue_vk),
    .issue_qk     (issue_qk),
    .issue_ready  (issue_ready),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .start        (start),
    .ID_RS        (ID_RS),
    .Dado1        (Dado1),
    .Dado2        (Dado2),
    .Dado3        (Dado3),
    .OP_Rd        (OP_Rd),
    .busy         (busy),
    .confirmacao  (confirmacao),
    .finalizado   (finalizado),
`ifdef RS_LS_FLUSH_EN
    .flush        (flush),
`endif
    .occupancy    (occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [15:0] off,
                             input logic [15:0] vj, input logic [3:0] qj,
                             input logic [15:0] vk, input logic [3:0] qk);
    issue_valid  = 1'b1;
    issue_op     = op;
    issue_offset = off;
    issue_vj     = vj;
    issue_qj     = qj;
    issue_vk     = vk;
    issue_qk     = qk;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    tick();
    tick();
    checks++; if (start !== 1'b0)       begin errors++; $display("FAIL rst_start got=%0h exp=0", start); end
    checks++; if (finalizado !== 1'b0)  begin errors++; $display("FAIL rst_fin got=%0h exp=0", finalizado); end
    checks++; if (ID_RS !== 4'd0)       begin errors++; $display("FAIL rst_id got=%0h exp=0", ID_RS); end
    checks++; if ({Dado1, Dado2, Dado3} !== 48'd0) begin errors++; $display("FAIL rst_dado got=%0h exp=0", {Dado1, Dado2, Dado3}); end
    checks++; if (OP_Rd !== 6'd0)       begin errors++; $display("FAIL rst_op got=%0h exp=0", OP_Rd); end
    checks++; if (occupancy !== 4'd0)   begin errors++; $display("FAIL rst_occ got=%0h exp=0", occupancy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0h exp=1", issue_ready); end
    CLR = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    drive_issue(LW_R2, 16'd4, 16'h0010, 4'd0, 16'd0, 4'd0);
    tick();
    issue_valid = 1'b0;
    checks++; if (start !== 1'b0)     begin errors++; $display("FAIL lw_start_early got=%0h exp=0", start); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL lw_occ1 got=%0h exp=1", occupancy); end
    tick();
    checks++; if (start !== 1'b1)       begin errors++; $display("FAIL lw_start got=%0h exp=1", start); end
    checks++; if (ID_RS !== 4'd5)       begin errors++; $display("FAIL lw_id got=%0h exp=5", ID_RS); end
    checks++; if (Dado1 !== 16'd4)      begin errors++; $display("FAIL lw_dado1 got=%0h exp=4", Dado1); end
    checks++; if (Dado2 !== 16'h0010)   begin errors++; $display("FAIL lw_dado2 got=%0h exp=10", Dado2); end
    checks++; if (OP_Rd !== LW_R2)      begin errors++; $display("FAIL lw_op got=%0h exp=%0h", OP_Rd, LW_R2); end
    confirmacao = 1'b1;
    tick();
    confirmacao = 1'b0;
    checks++; if (finalizado !== 1'b1) begin errors++; $display("FAIL lw_fin got=%0h exp=1", finalizado); end
    checks++; if (start !== 1'b0)      begin errors++; $display("FAIL lw_start_once got=%0h exp=0", start); end
    checks++; if (Dado1 !== 16'd4)     begin errors++; $display("FAIL lw_dado1_hold got=%0h exp=4", Dado1); end
    tick();
    checks++; if (finalizado !== 1'b0) begin errors++; $display("FAIL lw_fin_once got=%0h exp=0", finalizado); end
    checks++; if (occupancy !== 4'd0)  begin errors++; $display("FAIL lw_occ0 got=%0h exp=0", occupancy); end
  endtask

  task automatic test_sw_cdb();
    drive_issue(SW_R0, 16'd8, 16'h0100, 4'd0, 16'd0, 4'd7);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL sw_wait%0d got=%0h exp=0", i, start); end
    end
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 16'hBEEF;
    tick();
    cdb_valid = 1'b0;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL sw_pre got=%0h exp=0", start); end
    tick();
    checks++; if (start !== 1'b1)      begin errors++; $display("FAIL sw_start got=%0h exp=1", start); end
    checks++; if (Dado3 !== 16'hBEEF)  begin errors++; $display("FAIL sw_dado3 got=%0h exp=beef", Dado3); end
    checks++; if (Dado2 !== 16'h0100)  begin errors++; $display("FAIL sw_dado2 got=%0h exp=100", Dado2); end
    checks++; if (OP_Rd !== SW_R0)     begin errors++; $display("FAIL sw_op got=%0h exp=%0h", OP_Rd, SW_R0); end
    confirmacao = 1'b1;
    tick();
    confirmacao = 1'b0;
    checks++; if (finalizado !== 1'b1) begin errors++; $display("FAIL sw_fin got=%0h exp=1", finalizado); end
    tick();
  endtask

  task automatic test_bypass();
    drive_issue(LW_R3, 16'd12, 16'hDEAD, 4'd6, 16'd0, 4'd0);
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 16'h1234;
    tick();
    issue_valid = 1'b0; cdb_valid = 1'b0;
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL byp_occ got=%0h exp=1", occupancy); end
    tick();
    checks++; if (start !== 1'b1)     begin errors++; $display("FAIL byp_start got=%0h exp=1", start); end
    checks++; if (Dado2 !== 16'h1234) begin errors++; $display("FAIL byp_dado2 got=%0h exp=1234", Dado2); end
    confirmacao = 1'b1;
    tick();
    confirmacao = 1'b0;
    tick();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL byp_occ0 got=%0h exp=0", occupancy); end
  endtask

  task automatic test_back_to_back();
    drive_issue(LW_R2, 16'h0020, 16'h0040, 4'd0, 16'd0, 4'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    checks++; if (ID_RS !== 4'd5) begin errors++; $display("FAIL b2b_id0 got=%0h exp=5", ID_RS); end
    confirmacao = 1'b1;
    tick();
    confirmacao = 1'b0;
    // FIN cycle: free slot 0, issue into slot 1 and resolve its store data via bypass.
    drive_issue(SW_R0, 16'h0030, 16'h0050, 4'd0, 16'd0, 4'd9);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 16'h5555;
    checks++; if (finalizado !== 1'b1) begin errors++; $display("FAIL b2b_fin got=%0h exp=1", finalizado); end
    tick();
    issue_valid = 1'b0; cdb_valid = 1'b0;
    checks++; if (occupancy !== 4'd1)  begin errors++; $display("FAIL b2b_occ got=%0h exp=1", occupancy); end
    tick();
    checks++; if (start !== 1'b1)      begin errors++; $display("FAIL b2b_start got=%0h exp=1", start); end
    checks++; if (ID_RS !== 4'd6)      begin errors++; $display("FAIL b2b_id1 got=%0h exp=6", ID_RS); end
    checks++; if (Dado1 !== 16'h0030)  begin errors++; $display("FAIL b2b_dado1 got=%0h exp=30", Dado1); end
    checks++; if (Dado3 !== 16'h5555)  begin errors++; $display("FAIL b2b_dado3 got=%0h exp=5555", Dado3); end
    confirmacao = 1'b1;
    tick();
    confirmacao = 1'b0;
    tick();
    checks++; if (occupancy !== 4'd0)  begin errors++; $display("FAIL b2b_occ0 got=%0h exp=0", occupancy); end
  endtask

  task automatic test_full_busy();
    busy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive_issue({3'(k), 3'b100}, 16'(k), 16'h0100 + 16'(k), 4'd0, 16'd0, 4'd0);
      tick();
    end
    drive_issue(LW_R2, 16'd5, 16'h0105, 4'd0, 16'd0, 4'd0);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0h exp=0", issue_ready); end
    checks++; if (occupancy !== 4'd4)   begin errors++; $display("FAIL full_occ got=%0h exp=4", occupancy); end
    tick();
    issue_valid = 1'b0;
    checks++; if (occupancy !== 4'd4)   begin errors++; $display("FAIL full_drop got=%0h exp=4", occupancy); end
    tick();
    tick();
    checks++; if (start !== 1'b0)       begin errors++; $display("FAIL busy_hold got=%0h exp=0", start); end
    busy = 1'b0;
    tick();
    checks++; if (start !== 1'b1)       begin errors++; $display("FAIL busy_rel_start got=%0h exp=1", start); end
    checks++; if (ID_RS !== 4'd5)       begin errors++; $display("FAIL busy_rel_id got=%0h exp=5", ID_RS); end
    checks++; if (Dado1 !== 16'd1)      begin errors++; $display("FAIL busy_rel_dado1 got=%0h exp=1", Dado1); end
    confirmacao = 1'b1;
    tick();
    confirmacao = 1'b0;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL fin_ready_still got=%0h exp=0", issue_ready); end
    tick();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL freed_ready got=%0h exp=1", issue_ready); end
    checks++; if (occupancy !== 4'd3)   begin errors++; $display("FAIL freed_occ got=%0h exp=3", occupancy); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++; if (start !== 1'b1)            begin errors++; $display("FAIL drain%0d_start got=%0h exp=1", k, start); end
      checks++; if (ID_RS !== 4'(4 + k))       begin errors++; $display("FAIL drain%0d_id got=%0h exp=%0h", k, ID_RS, 4 + k); end
      checks++; if (Dado1 !== 16'(k))          begin errors++; $display("FAIL drain%0d_dado1 got=%0h exp=%0h", k, Dado1, k); end
      checks++; if (Dado2 !== 16'(16'h100 + k)) begin errors++; $display("FAIL drain%0d_dado2 got=%0h exp=%0h", k, Dado2, 16'h100 + k); end
      confirmacao = 1'b1;
      tick();
      confirmacao = 1'b0;
      checks++; if (finalizado !== 1'b1)       begin errors++; $display("FAIL drain%0d_fin got=%0h exp=1", k, finalizado); end
      tick();
    end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL drain_occ got=%0h exp=0", occupancy); end
    tick();
    checks++; if (start !== 1'b0)     begin errors++; $display("FAIL dropped_dispatched got=%0h exp=0", start); end
  endtask

  task automatic test_clr_wait();
    drive_issue(LW_R3, 16'h0077, 16'h0099, 4'd0, 16'd0, 4'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL clr_pre_start got=%0h exp=1", start); end
    CLR = 1'b1;
    confirmacao = 1'b1;
    tick();
    CLR = 1'b0;
    confirmacao = 1'b0;
    checks++; if (start !== 1'b0)       begin errors++; $display("FAIL clr_start got=%0h exp=0", start); end
    checks++; if (finalizado !== 1'b0)  begin errors++; $display("FAIL clr_fin got=%0h exp=0", finalizado); end
    checks++; if (ID_RS !== 4'd0)       begin errors++; $display("FAIL clr_id got=%0h exp=0", ID_RS); end
    checks++; if ({Dado1, Dado2, Dado3} !== 48'd0) begin errors++; $display("FAIL clr_dado got=%0h exp=0", {Dado1, Dado2, Dado3}); end
    checks++; if (OP_Rd !== 6'd0)       begin errors++; $display("FAIL clr_op got=%0h exp=0", OP_Rd); end
    checks++; if (occupancy !== 4'd0)   begin errors++; $display("FAIL clr_occ got=%0h exp=0", occupancy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL clr_ready got=%0h exp=1", issue_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (finalizado !== 1'b0) begin errors++; $display("FAIL clr_post_fin%0d got=%0h exp=0", i, finalizado); end
      checks++; if (start !== 1'b0)      begin errors++; $display("FAIL clr_post_start%0d got=%0h exp=0", i, start); end
    end
  endtask

  initial begin
    CLR = 1'b1;
    issue_valid = 1'b0; issue_op = '0; issue_offset = '0;
    issue_vj = '0; issue_qj = '0; issue_vk = '0; issue_qk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    busy = 1'b0; confirmacao = 1'b0;
`ifdef RS_LS_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    test_reset();
    test_lw();
    test_sw_cdb();
    test_bypass();
    test_back_to_back();
    test_full_busy();
    test_clr_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
